// File: rtl/mac_pkg.sv
// Shared types and constants for the dot-product accumulator slice.
// Contents: accumulator FSM state enum, product width helpers and a
// saturation-constant function returning an all-ones word of a given width.
package mac_pkg;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } acc_state_t;

    // Upper bound on accumulator width supported by all_ones().
    localparam int MAX_ACC_WIDTH      = 128;
    localparam int DEFAULT_DATA_WIDTH = 16;

    function automatic int product_width(input int data_width);
        return 2 * data_width;
    endfunction

    localparam int PRODUCT_WIDTH = product_width(DEFAULT_DATA_WIDTH);

    // Returns a word with the low 'width' bits set; callers slice it down.
    function automatic logic [MAX_ACC_WIDTH-1:0] all_ones(input int width);
        logic [MAX_ACC_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_ACC_WIDTH; i++) begin
            if (i < width) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/product_pipe_reg.sv
// One-entry valid/data/last pipeline register (stage 1 of the accumulator).
// Ports: load_i captures data_i/last_i, drain_i empties the entry, clear_i
// empties it with highest priority; vld_o/data_o/last_o expose the entry.
module product_pipe_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o
);

    logic             vld_q,  vld_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;

    // A load in the same cycle as a drain replaces the entry, which is what
    // gives one product per cycle while accumulating.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        last_d = last_q;
        if (clear_i) begin
            vld_d = 1'b0;
        end else if (load_i) begin
            vld_d  = 1'b1;
            data_d = data_i;
            last_d = last_i;
        end else if (drain_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            last_q <= last_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign last_o = last_q;

endmodule

// File: rtl/dot_product_accumulator.sv
// Registers multiplier products, sums each last-delimited packet into a
// saturating accumulator and presents sum/count/overflow on valid/ready.
// Ports: product/product_valid/product_last/product_ready in, result*
// with result_valid/result_ready out, sync_clear aborts the current packet.
module dot_product_accumulator
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH  = PRODUCT_WIDTH / 2,
    parameter int ACC_WIDTH   = 40,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sync_clear,
    input  logic [2*DATA_WIDTH-1:0] product,
    input  logic                    product_valid,
    input  logic                    product_last,
    output logic                    product_ready,
    output logic [ACC_WIDTH-1:0]    result,
    output logic [COUNT_WIDTH-1:0]  result_count,
    output logic                    result_overflow,
    output logic                    result_valid,
    input  logic                    result_ready
);

    localparam int                       PW        = product_width(DATA_WIDTH);
    localparam logic [MAX_ACC_WIDTH-1:0] ONES_FULL = all_ones(ACC_WIDTH);
    localparam logic [ACC_WIDTH-1:0]     ACC_MAX   = ONES_FULL[ACC_WIDTH-1:0];
    localparam logic [COUNT_WIDTH-1:0]   CNT_MAX   = '1;

    acc_state_t             state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q,   acc_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   ovf_q,   ovf_d;

    logic          s1_valid;
    logic [PW-1:0] s1_product;
    logic          s1_last;
    logic          accept;
    logic          consume;
    logic [ACC_WIDTH:0] sum;

    // sync_clear drops any product offered in the same cycle.
    assign product_ready = !sync_clear && ((state_q == ACCUM) || !s1_valid);
    assign accept        = product_valid && product_ready;
    assign consume       = (state_q == ACCUM) && s1_valid;

    product_pipe_reg #(
        .WIDTH (PW)
    ) u_stage1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept),
        .drain_i (consume),
        .clear_i (sync_clear),
        .data_i  (product),
        .last_i  (product_last),
        .vld_o   (s1_valid),
        .data_o  (s1_product),
        .last_o  (s1_last)
    );

    // One spare bit catches the carry out; an already-saturated acc plus any
    // product either carries or stays all-ones, so saturation is sticky.
    assign sum = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - PW){1'b0}}, s1_product};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (sync_clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (consume) begin
                        if (sum[ACC_WIDTH]) begin
                            acc_d = ACC_MAX;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum[ACC_WIDTH-1:0];
                        end
                        if (count_q != CNT_MAX) begin
                            count_d = count_q + 1'b1;
                        end
                        if (s1_last) begin
                            state_d = OUTPUT;
                        end
                    end
                end
                OUTPUT: begin
                    if (result_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign result_valid    = (state_q == OUTPUT);
    assign result          = acc_q;
    assign result_count    = count_q;
    assign result_overflow = ovf_q;

endmodule
